// File: rtl/proc_pkg.sv
// Shared definitions for the five-stage pipeline: sequencer state encodings,
// register-index width and the default halt drain length.
package proc_pkg;

    localparam int REG_W            = 3;
    localparam int DRAIN_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction
// in ID reads. r0 is treated like any other register.
module hazard_detect
    import proc_pkg::*;
(
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_used,
    input  logic             i_id_rt_used,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_memread,
    output logic             o_luh
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_id_rs_used & (i_id_rs == i_ex_rd);
    assign w_rt_hit = i_id_rt_used & (i_id_rt == i_ex_rd);
    assign o_luh    = i_ex_memread & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: PC/pipeline-register enables and flushes, load-use
// bubbles, redirect flushes, memory-busy freezes and the halt drain.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_RUN    | normal issue, priority mux picks stall/flush pattern
//   ST_DRAIN  | halt left ID; bubbles fed in while EX/MEM/WB retire
//   ST_HALTED | pipeline empty, everything frozen until reset
module hazard_ctrl
    import proc_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_used,
    input  logic             i_id_rt_used,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_memread,
    input  logic             i_ex_redirect,
    input  logic             i_id_halt,
    input  logic             i_imem_busy,
    input  logic             i_dmem_busy,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_err
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_drain_cnt;
    logic [DW-1:0]    w_drain_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_halted;
    logic             r_err;
    logic             w_err_set;
    logic             w_luh;

    hazard_detect u_hazard_detect (
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_rs_used (i_id_rs_used),
        .i_id_rt_used (i_id_rt_used),
        .i_ex_rd      (i_ex_rd),
        .i_ex_memread (i_ex_memread),
        .o_luh        (w_luh)
    );

    always_comb begin
        o_pc_en      = 1'b1;
        o_ifid_en    = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_en    = 1'b1;
        o_idex_flush = 1'b0;
        o_exmem_en   = 1'b1;
        o_memwb_en   = 1'b1;
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain_cnt;
        w_err_set    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_dmem_busy) begin
                    o_pc_en    = 1'b0;
                    o_ifid_en  = 1'b0;
                    o_idex_en  = 1'b0;
                    o_exmem_en = 1'b0;
                    o_memwb_en = 1'b0;
                end else if (i_ex_redirect) begin
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (w_luh) begin
                    o_pc_en      = 1'b0;
                    o_ifid_en    = 1'b0;
                    o_idex_flush = 1'b1;
                end else if (i_imem_busy) begin
                    o_pc_en      = 1'b0;
                    o_ifid_flush = 1'b1;
                end else if (i_id_halt) begin
                    o_pc_en      = 1'b0;
                    o_ifid_flush = 1'b1;
                    w_drain_nxt  = DW'(DRAIN_CYCLES);
                    w_state_nxt  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_pc_en      = 1'b0;
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
                w_err_set    = i_id_halt;
                // A busy MEM stage freezes EX too, otherwise the bubble would overwrite it.
                if (i_dmem_busy) begin
                    o_ifid_en  = 1'b0;
                    o_idex_en  = 1'b0;
                    o_exmem_en = 1'b0;
                    o_memwb_en = 1'b0;
                end else begin
                    w_drain_nxt = r_drain_cnt - DW'(1);
                    if (r_drain_cnt <= DW'(1)) begin
                        w_drain_nxt = '0;
                        w_state_nxt = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                o_pc_en    = 1'b0;
                o_ifid_en  = 1'b0;
                o_idex_en  = 1'b0;
                o_exmem_en = 1'b0;
                o_memwb_en = 1'b0;
                w_err_set  = i_ex_redirect | i_id_halt;
            end
            default: begin
                o_pc_en     = 1'b0;
                o_ifid_en   = 1'b0;
                o_idex_en   = 1'b0;
                o_exmem_en  = 1'b0;
                o_memwb_en  = 1'b0;
                w_err_set   = 1'b1;
                w_drain_nxt = '0;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_halted    <= (w_state_nxt == ST_HALTED);
            r_err       <= r_err | w_err_set;
            if ((r_state == ST_RUN) && !o_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_halted    = r_halted;
    assign o_stall_cnt = r_stall_cnt;
    assign o_err       = r_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a RUN-state priority table plus hand-written
// load-use, freeze, halt-drain, mid-drain reset and counter-saturation sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       id_rs_used, id_rt_used, ex_memread, ex_redirect, id_halt, imem_busy, dmem_busy;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted, err;
    logic [15:0] stall_cnt;
    logic        pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4, exmem_en4, memwb_en4, halted4, err4;
    logic [3:0]  stall_cnt4;

    logic [6:0] en, en4;
    assign en  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
    assign en4 = {pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4, exmem_en4, memwb_en4};

    // enable-vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en
    localparam logic [6:0] EN_DEF   = 7'b1101011;
    localparam logic [6:0] EN_LUH   = 7'b0001111;
    localparam logic [6:0] EN_REDIR = 7'b1111111;
    localparam logic [6:0] EN_IBUSY = 7'b0111011;
    localparam logic [6:0] EN_FRZ   = 7'b0000000;
    localparam logic [6:0] EN_DRAIN = 7'b0111111;
    localparam logic [6:0] EN_DRBSY = 7'b0010100;

    int n_vec = 0;
    int n_bad = 0;
    int exp_stall;

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_rs_used(id_rs_used), .i_id_rt_used(id_rt_used), .i_ex_rd(ex_rd),
        .i_ex_memread(ex_memread), .i_ex_redirect(ex_redirect), .i_id_halt(id_halt),
        .i_imem_busy(imem_busy), .i_dmem_busy(dmem_busy),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
        .o_idex_en(idex_en), .o_idex_flush(idex_flush), .o_exmem_en(exmem_en),
        .o_memwb_en(memwb_en), .o_halted(halted), .o_stall_cnt(stall_cnt), .o_err(err)
    );

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_rs_used(id_rs_used), .i_id_rt_used(id_rt_used), .i_ex_rd(ex_rd),
        .i_ex_memread(ex_memread), .i_ex_redirect(ex_redirect), .i_id_halt(id_halt),
        .i_imem_busy(imem_busy), .i_dmem_busy(dmem_busy),
        .o_pc_en(pc_en4), .o_ifid_en(ifid_en4), .o_ifid_flush(ifid_flush4),
        .o_idex_en(idex_en4), .o_idex_flush(idex_flush4), .o_exmem_en(exmem_en4),
        .o_memwb_en(memwb_en4), .o_halted(halted4), .o_stall_cnt(stall_cnt4), .o_err(err4)
    );

    typedef struct {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rsu;
        logic       rtu;
        logic [2:0] rd;
        logic       mr;
        logic       rdr;
        logic       hlt;
        logic       ib;
        logic       db;
        logic [6:0] exp_en;
    } vec_t;

    vec_t vecs[15];

    task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic rsu,
                         input logic rtu, input logic [2:0] rd, input logic mr,
                         input logic rdr, input logic hlt, input logic ib, input logic db);
        id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu; ex_rd = rd;
        ex_memread = mr; ex_redirect = rdr; id_halt = hlt; imem_busy = ib; dmem_busy = db;
    endtask

    task automatic idle();
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_en(input string nm, input logic [6:0] act, input logic [6:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: enables got %b expected %b", nm, act, exp_v);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        check_en({nm, "_en"}, en, EN_DEF);
        check_val({nm, "_stall"}, int'(stall_cnt), 0);
        check_val({nm, "_halted"}, int'(halted), 0);
        check_val({nm, "_err"}, int'(err), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EN_DEF};
        vecs[1]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EN_LUH};
        vecs[2]  = '{3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EN_DEF};
        vecs[3]  = '{3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EN_LUH};
        vecs[4]  = '{3'd5, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EN_DEF};
        vecs[5]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, EN_REDIR};
        vecs[6]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, EN_IBUSY};
        vecs[7]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, EN_REDIR};
        vecs[8]  = '{3'd4, 3'd6, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, EN_LUH};
        vecs[9]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, EN_FRZ};
        vecs[10] = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, EN_LUH};
        vecs[11] = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, EN_REDIR};
        vecs[12] = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, EN_FRZ};
        vecs[13] = '{3'd2, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EN_DEF};
        vecs[14] = '{3'd7, 3'd2, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EN_DEF};

        rst = 1'b0;
        idle();
        do_reset("reset0");

        // RUN priority table; halt rows are all masked by a higher-priority condition
        exp_stall = 0;
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rs, vecs[i].rt, vecs[i].rsu, vecs[i].rtu, vecs[i].rd,
                  vecs[i].mr, vecs[i].rdr, vecs[i].hlt, vecs[i].ib, vecs[i].db);
            #1;
            check_en($sformatf("vec%0d", i), en, vecs[i].exp_en);
            if (!vecs[i].exp_en[6]) exp_stall++;
        end
        @(negedge clk);
        idle();
        #1;
        check_en("table_still_run", en, EN_DEF);
        check_val("table_stall", int'(stall_cnt), exp_stall);
        check_val("table_err", int'(err), 0);

        // Load-use single bubble
        do_reset("reset_luh");
        @(negedge clk);
        drive(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_en("luh_bubble", en, EN_LUH);
        @(negedge clk);
        ex_memread = 1'b0;
        #1 check_en("luh_release", en, EN_DEF);
        check_val("luh_stall", int'(stall_cnt), 1);

        // Redirect overrides load-use
        @(negedge clk);
        drive(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_en("redir_luh", en, EN_REDIR);
        @(negedge clk);
        idle();
        #1 check_val("redir_stall", int'(stall_cnt), 1);

        // dmem_busy freezes over a pending load-use, then the bubble resumes
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            #1 check_en($sformatf("freeze%0d", c), en, EN_FRZ);
        end
        @(negedge clk);
        dmem_busy = 1'b0;
        #1 check_en("freeze_luh", en, EN_LUH);
        @(negedge clk);
        idle();
        #1 check_val("freeze_stall", int'(stall_cnt), 6);

        // Halt drain with a dmem_busy pulse on the second drain cycle
        @(negedge clk);
        id_halt = 1'b1;
        #1 check_en("halt_accept", en, EN_IBUSY);
        @(negedge clk);
        idle();
        #1 check_en("drain1", en, EN_DRAIN);
        check_val("drain1_halted", int'(halted), 0);
        @(negedge clk);
        dmem_busy = 1'b1;
        #1 check_en("drain2_busy", en, EN_DRBSY);
        @(negedge clk);
        dmem_busy = 1'b0;
        #1 check_en("drain3", en, EN_DRAIN);
        check_val("drain3_halted", int'(halted), 0);
        @(negedge clk);
        #1 check_en("drain4", en, EN_DRAIN);
        check_val("drain4_halted", int'(halted), 0);
        @(negedge clk);
        #1 check_en("halted_en", en, EN_FRZ);
        check_val("halted_flag", int'(halted), 1);
        check_val("halted_stall", int'(stall_cnt), 7);
        check_val("halted_err0", int'(err), 0);
        @(negedge clk);
        id_halt = 1'b1;
        #1 check_en("halted_halt_en", en, EN_FRZ);
        @(negedge clk);
        id_halt = 1'b0;
        #1 check_val("halted_err1", int'(err), 1);
        check_val("halted_hold", int'(halted), 1);

        // Reset asserted mid-drain
        do_reset("reset_pre_drain");
        @(negedge clk);
        id_halt = 1'b1;
        @(negedge clk);
        idle();
        #1 check_en("redrain", en, EN_DRAIN);
        #1 rst = 1'b0;
        #1 check_en("rst_mid_drain_en", en, EN_DEF);
        check_val("rst_mid_drain_stall", int'(stall_cnt), 0);
        check_val("rst_mid_drain_halted", int'(halted), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 check_en($sformatf("post_rst%0d", c), en, EN_DEF);
        end
        check_val("post_rst_halted", int'(halted), 0);

        // Stall counter saturation on the 4-bit instance
        do_reset("reset_sat");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            imem_busy = 1'b1;
            #1 check_en($sformatf("sat16_%0d", c), en, EN_IBUSY);
            check_en($sformatf("sat4_%0d", c), en4, EN_IBUSY);
        end
        @(negedge clk);
        idle();
        #1 check_val("sat4_cnt", int'(stall_cnt4), 15);
        check_val("sat16_cnt", int'(stall_cnt), 20);
        @(negedge clk);
        imem_busy = 1'b1;
        @(negedge clk);
        idle();
        #1 check_val("sat4_hold", int'(stall_cnt4), 15);
        check_val("sat4_halted", int'(halted4), 0);
        check_val("sat4_err", int'(err4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the five-stage processor (IF, ID, EX, MEM, WB).
- Generates the PC write enable and the per-pipeline-register enables and flushes that the fetch, IF/ID, ID/EX, EX/MEM and MEM/WB registers consume.
- Detects load-use hazards, applies control-transfer redirect flushes and handles memory busy stalls.
- Sequences the halt drain so the pipeline empties before the processor reports halted.

Parameters:
- DRAIN_CYCLES, 3, cycles after halt leaves ID before halted asserts (EX, MEM, WB retire).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  3  source register 1 of the instruction in ID.
- id_rt  in  3  source register 2 of the instruction in ID.
- id_rs_used  in  1  ID instruction reads id_rs.
- id_rt_used  in  1  ID instruction reads id_rt.
- ex_rd  in  3  destination register of the instruction in EX.
- ex_memread  in  1  instruction in EX is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX.
- id_halt  in  1  halt decoded in ID.
- imem_busy  in  1  instruction memory cannot return an instruction this cycle.
- dmem_busy  in  1  data memory cannot complete the MEM access this cycle.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  load a bubble (all control bits 0) into ID/EX.
- exmem_en  out  1  EX/MEM load enable.
- memwb_en  out  1  MEM/WB load enable.
- halted  out  1  pipeline drained after halt.
- stall_cnt  out  CNT_W  cycles in which pc_en was 0 while in RUN.
- err  out  1  illegal condition flag.

Behaviour:
- State machine with three states, held in a registered 2-bit encoding: RUN=0, DRAIN=1, HALTED=2.
- Drain counter: registered, width $clog2(DRAIN_CYCLES+1).
- All enable and flush outputs are combinational from the inputs and the registered state. halted, stall_cnt and err are registered.
- Reset (rst=0, asynchronous):
  - state=RUN, drain counter=0, stall_cnt=0, halted=0, err=0.
  - Combinational outputs then take their RUN values.
  - Reset asserted mid-DRAIN or in HALTED returns immediately to RUN.
- Load-use hazard:
  - luh = ex_memread & (ex_rd!=0 or any register; r0 is not special) & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- RUN priority, highest first; default is all enables 1 and all flushes 0:
  1. dmem_busy: all five enables 0, no flushes. The whole pipeline freezes.
  2. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1. Redirect overrides luh and imem_busy. If imem_busy is also high, pc_en stays 1 so the new target is latched.
  3. luh: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble; the next cycle luh is 0 because the load has moved to MEM.
  4. imem_busy: pc_en=0, ifid_flush=1. ID/EX and later stages advance.
  5. id_halt: pc_en=0, ifid_flush=1, drain counter loaded with DRAIN_CYCLES, next state DRAIN.
- id_halt is ignored in the same cycle as dmem_busy, ex_redirect or luh; the halt is wrong-path, or it is re-presented next cycle.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1; later stages advance unless dmem_busy.
  - Counter decrements only when dmem_busy=0.
  - At counter==1 with dmem_busy=0, next state HALTED.
- HALTED: all enables 0, halted=1 from the first HALTED cycle, stable until reset.
- stall_cnt:
  - Increments in RUN whenever pc_en=0.
  - Saturates at all-ones, no wrap.
- err: sticky once set, cleared only by reset. It is set on:
  - an illegal state encoding (3);
  - ex_redirect=1 in HALTED;
  - id_halt=1 in DRAIN or HALTED.

Decomposition:
- Shared package (proc_pkg): state encodings RUN/DRAIN/HALTED and the DRAIN_CYCLES default. The same package is used by the other pipeline-register modules.
- One sub-module, hazard_detect: the purely combinational luh compare, instantiated inside hazard_ctrl.
- The state machine, counters and priority mux stay in the top module.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_rs_used=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle. Next cycle (ex_memread=0): all enables 1. stall_cnt=1.
- Redirect plus load-use in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1. stall_cnt unchanged.
- dmem_busy held for 4 cycles during luh -> all enables 0 and no flushes for those 4 cycles, then luh behaviour resumes. stall_cnt increments by 5 total.
- Halt with DRAIN_CYCLES=3 and a dmem_busy pulse on the 2nd drain cycle:
  - id_halt=1 -> state DRAIN next cycle;
  - halted=1 exactly 4 cycles after the drain entry edge, with all enables 0;
  - a subsequent id_halt pulse -> err=1.
- Reset mid-DRAIN: rst low for 1 cycle -> immediately state=RUN, halted=0, stall_cnt=0, all enables 1.
- Saturation: CNT_W=4, imem_busy held for 20 cycles -> stall_cnt reaches 15 and stays there; ifid_flush=1 throughout.
